jtsdram_bank_seq: RTL
=====================

Name: jtsdram_bank_seq

Overview:
Test scheduler that sequences up to BANKS SDRAM bank verifiers, one at a time, over a configurable number of loops.
- Issues a one-cycle start pulse to the selected verifier and waits for its done level, with a watchdog timeout.
- Accumulates per-bank bad and timeout flags, counts completed loops and reports overall pass/fail.
- Sits between the top-level test control (buttons/OSD) and the per-bank verifier instances. Exactly one verifier runs at a time, so SDRAM bandwidth is never shared between tests.

Parameters:
BANKS, 4, number of verifier slots (2..8)
BW, 2, width of bank index, equal to clog2(BANKS)
TOW, 24, watchdog counter width; timeout after 2^TOW-1 cycles in WAIT
LOOPW, 8, width of loop request and loop counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
go  in  1  pulse; starts a test campaign when idle; ignored while busy
abort  in  1  pulse; ends the campaign at the next state boundary
loops  in  LOOPW  number of full passes; 0 = run forever (until abort)
bank_en  in  BANKS  enable mask, sampled on go
bank_done  in  BANKS  done level from each verifier
bank_bad  in  BANKS  sticky bad flag from each verifier
bank_start  out  BANKS  one-hot, one-cycle start pulse
active  out  BW  index of the bank currently under test
busy  out  1  campaign in progress
finished  out  1  high from campaign end until next go
ok  out  1  valid when finished: no bad, no timeout, no abort
bad_mask  out  BANKS  sticky per-bank bad flags, cleared on go
tout_mask  out  BANKS  sticky per-bank timeout flags, cleared on go
pass_cnt  out  LOOPW  completed full passes, saturating

Behaviour:
Reset (rst_n low, async):
- State IDLE.
- All outputs 0: bank_start, active, busy, finished, ok, bad_mask, tout_mask, pass_cnt.
- Latched enable mask 0, watchdog 0.

IDLE:
- On go with a nonzero bank_en: latch en_q=bank_en and loops_q=loops.
- Clear bad_mask, tout_mask, pass_cnt, finished, ok.
- Set busy=1 and active to the lowest set bit of bank_en. Next state LAUNCH.
- On go with bank_en==0: finished=1, ok=0, busy stays 0, stay in IDLE.

LAUNCH (1 cycle):
- bank_start[active]=1 for exactly this cycle; watchdog cleared.
- Next state ARM.

ARM (1 cycle):
- Ignore bank_done. The verifier clears done one cycle after start, so a stale done level must not be taken as completion.
- Next state WAIT.

WAIT:
- Watchdog increments every cycle.
- If bank_done[active]==1: bad_mask[active] |= bank_bad[active]. Next state NEXT.
- Else if the watchdog is all ones: tout_mask[active]=1. Next state NEXT.
- If done and watchdog-full occur in the same cycle, done wins; no timeout is flagged.

NEXT (1 cycle):
- Search for the next set bit of en_q strictly above active.
- If one is found: active=that index, go to LAUNCH.
- Otherwise a pass is complete:
  - pass_cnt+1, saturating at all ones.
  - If loops_q!=0 and the new pass_cnt==loops_q: go to END.
  - Else active=lowest set bit of en_q, go to LAUNCH.
- abort seen in any busy state is latched (abort_q) and acted on here: go to END without incrementing pass_cnt for a partial pass.

END (1 cycle):
- busy=0, finished=1.
- ok = (bad_mask==0) && (tout_mask==0) && !abort_q.
- Go to IDLE.

Other rules:
- abort in IDLE has no effect.
- go while busy is ignored.
- bank_done and bank_bad of inactive banks are ignored.
- Latency from go to the first bank_start pulse is 1 cycle: go is sampled in IDLE, the pulse is emitted in LAUNCH on the next cycle.
- Minimum bank-to-bank gap is 3 cycles (WAIT to NEXT to LAUNCH).
- pass_cnt saturates; it never wraps, including in forever mode.
- All outputs are registered.

Test Plan:
1. bank_en=4'b1011, loops=1; each verifier model asserts done 20 cycles after its start pulse, bad=0 -> start pulses appear on banks 0, 1, 3 in that order; bank 2 gets no pulse; pass_cnt=1; finished=1; ok=1; busy low after END.
2. bank_en=4'b0001, loops=3; bank 0 asserts bad on its second run -> three start pulses; bad_mask=4'b0001; pass_cnt=3; ok=0.
3. TOW=4, bank_en=4'b0011; bank 1 never asserts done -> tout_mask=4'b0010 exactly 15 WAIT cycles after bank 1's start; the campaign still finishes; ok=0.
4. loops=0, bank_en=4'b1111; abort asserted during bank 2 WAIT of the third pass -> END only after bank 2 completes; pass_cnt=2; ok=0; a go issued while busy is ignored.
5. Verifier done level left high from the previous run and dropped 1 cycle after start -> no premature advance; the sequencer waits for the fresh done.
6. rst_n pulled low mid-WAIT, then a new go -> all outputs return to 0 immediately; the new go restarts cleanly from the lowest enabled bank.

Source files
------------

// File: rtl/jtsdram_bank_seq.sv
// Bank test scheduler: runs the enabled SDRAM bank verifiers one after another
// and repeats the full pass a requested number of times, or forever. It keeps
// sticky per-bank bad and timeout flags and reports an overall verdict.
module jtsdram_bank_seq #(
    parameter int BANKS = 4,
    parameter int BW    = 2,
    parameter int TOW   = 24,
    parameter int LOOPW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic [LOOPW-1:0] loops,
    input  logic [BANKS-1:0] bank_en,
    input  logic [BANKS-1:0] bank_done,
    input  logic [BANKS-1:0] bank_bad,
    output logic [BANKS-1:0] bank_start,
    output logic [BW-1:0]    active,
    output logic             busy,
    output logic             finished,
    output logic             ok,
    output logic [BANKS-1:0] bad_mask,
    output logic [BANKS-1:0] tout_mask,
    output logic [LOOPW-1:0] pass_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_END    = 3'd5
    } state_t;

    // Index of the lowest set bit; the mask is never empty where this is used.
    function automatic logic [BW-1:0] lowest_bit(input logic [BANKS-1:0] mask);
        logic [BW-1:0] idx;
        idx = {BW{1'b0}};
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = BW'(i);
            end
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit strictly above cur.
    function automatic logic [BW:0] next_above(input logic [BANKS-1:0] mask,
                                              input logic [BW-1:0]    cur);
        logic [BW:0] res;
        res = {1'b0, {BW{1'b0}}};
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                res = {1'b1, BW'(i)};
            end
        end
        return res;
    endfunction

    // One-hot vector with only bit idx set.
    function automatic logic [BANKS-1:0] onehot(input logic [BW-1:0] idx);
        return {{(BANKS-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t           state_r;
    logic [BANKS-1:0] en_r;
    logic [LOOPW-1:0] loops_r;
    logic             abort_r;
    logic [TOW-1:0]   wdog_r;

    logic [TOW-1:0]   wdog_inc_s;
    logic             wdog_full_s;
    logic [LOOPW-1:0] pass_inc_s;
    logic [BW:0]      nxt_s;
    logic [BW-1:0]    first_go_s;
    logic [BW-1:0]    first_q_s;
    logic             done_act_s;
    logic             bad_act_s;

    // Next-value helpers for the watchdog, pass counter and bank selection.
    always_comb begin
        wdog_inc_s  = wdog_r + {{(TOW-1){1'b0}}, 1'b1};
        wdog_full_s = (wdog_inc_s == {TOW{1'b1}});
        pass_inc_s  = (pass_cnt == {LOOPW{1'b1}}) ? pass_cnt
                                                  : pass_cnt + {{(LOOPW-1){1'b0}}, 1'b1};
        nxt_s       = next_above(en_r, active);
        first_go_s  = lowest_bit(bank_en);
        first_q_s   = lowest_bit(en_r);
        done_act_s  = bank_done[active];
        bad_act_s   = bank_bad[active];
    end

    // Campaign state machine; every output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            en_r       <= {BANKS{1'b0}};
            loops_r    <= {LOOPW{1'b0}};
            abort_r    <= 1'b0;
            wdog_r     <= {TOW{1'b0}};
            bank_start <= {BANKS{1'b0}};
            active     <= {BW{1'b0}};
            busy       <= 1'b0;
            finished   <= 1'b0;
            ok         <= 1'b0;
            bad_mask   <= {BANKS{1'b0}};
            tout_mask  <= {BANKS{1'b0}};
            pass_cnt   <= {LOOPW{1'b0}};
        end else begin
            bank_start <= {BANKS{1'b0}};
            // An abort is remembered and only acted on at the end of a bank run.
            if (busy && abort) begin
                abort_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (go) begin
                        if (bank_en != {BANKS{1'b0}}) begin
                            en_r       <= bank_en;
                            loops_r    <= loops;
                            abort_r    <= 1'b0;
                            bad_mask   <= {BANKS{1'b0}};
                            tout_mask  <= {BANKS{1'b0}};
                            pass_cnt   <= {LOOPW{1'b0}};
                            finished   <= 1'b0;
                            ok         <= 1'b0;
                            busy       <= 1'b1;
                            active     <= first_go_s;
                            bank_start <= onehot(first_go_s);
                            state_r    <= ST_LAUNCH;
                        end else begin
                            finished <= 1'b1;
                            ok       <= 1'b0;
                        end
                    end
                end
                ST_LAUNCH: begin
                    wdog_r  <= {TOW{1'b0}};
                    state_r <= ST_ARM;
                end
                ST_ARM: begin
                    // The verifier's done level may still be stale here.
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    wdog_r <= wdog_inc_s;
                    if (done_act_s) begin
                        if (bad_act_s) begin
                            bad_mask <= bad_mask | onehot(active);
                        end
                        state_r <= ST_NEXT;
                    end else if (wdog_full_s) begin
                        tout_mask <= tout_mask | onehot(active);
                        state_r   <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (abort_r || abort) begin
                        abort_r  <= 1'b1;
                        busy     <= 1'b0;
                        finished <= 1'b1;
                        ok       <= 1'b0;
                        state_r  <= ST_END;
                    end else if (nxt_s[BW]) begin
                        active     <= nxt_s[BW-1:0];
                        bank_start <= onehot(nxt_s[BW-1:0]);
                        state_r    <= ST_LAUNCH;
                    end else begin
                        pass_cnt <= pass_inc_s;
                        if ((loops_r != {LOOPW{1'b0}}) && (pass_inc_s == loops_r)) begin
                            busy     <= 1'b0;
                            finished <= 1'b1;
                            ok       <= (bad_mask == {BANKS{1'b0}}) &&
                                        (tout_mask == {BANKS{1'b0}});
                            state_r  <= ST_END;
                        end else begin
                            active     <= first_q_s;
                            bank_start <= onehot(first_q_s);
                            state_r    <= ST_LAUNCH;
                        end
                    end
                end
                ST_END: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
